plru_replace_ctrl: RTL and testbench

Per-set tree-PLRU replacement controller for a set-associative cache. Holds one PLRU tree per set in flop storage. Serves two requesters: hit "touch" updates from the lookup path, and "victim" requests from the refill path. A victim request returns the oldest way and marks it MRU atomically. Sits beside the tag array; it clears its storage sequentially after reset and on flush.

---
 rtl/plru_replace_ctrl.sv | 118 +++++++++++
 tb/tb_plru_replace_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plru_replace_ctrl.sv
// Per-set tree-PLRU replacement controller: arbitrates hit touches against
// victim requests, one op per cycle through a single read-modify-write stage.
module plru_replace_ctrl #(
  parameter int NUM_OF_SETS    = 64,
  parameter int NUM_OF_WAYS    = 4,
  localparam int SET_IDX_WIDTH  = $clog2(NUM_OF_SETS),
  localparam int WAYS_IDX_WIDTH = $clog2(NUM_OF_WAYS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      touch_valid,
  output logic                      touch_ready,
  input  logic [SET_IDX_WIDTH-1:0]  touch_set,
  input  logic [WAYS_IDX_WIDTH-1:0] touch_way,
  input  logic                      victim_valid,
  output logic                      victim_ready,
  input  logic [SET_IDX_WIDTH-1:0]  victim_set,
  output logic                      victim_rsp_valid,
  output logic [SET_IDX_WIDTH-1:0]  victim_rsp_set,
  output logic [WAYS_IDX_WIDTH-1:0] victim_rsp_way,
  input  logic                      flush_req,
  output logic                      init_done
);

  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [SET_IDX_WIDTH-1:0]  init_cnt_q;
  logic                      last_victim_q;
  logic                      s1_valid_q, s1_victim_q;
  logic [SET_IDX_WIDTH-1:0]  s1_set_q;
  logic [WAYS_IDX_WIDTH-1:0] s1_way_q;
  logic [NUM_OF_WAYS-1:0]    tree_mem [NUM_OF_SETS];

  logic                      open, both, touch_acc, victim_acc;
  logic [NUM_OF_WAYS-1:0]    rd_tree, new_tree;
  logic [WAYS_IDX_WIDTH:0]   walk, climb;
  logic [WAYS_IDX_WIDTH-1:0] vic_way, upd_way;

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    open         = (state_q == RUN) && !flush_req;
    both         = touch_valid && victim_valid;
    touch_ready  = open && !(both && !last_victim_q);
    victim_ready = open && !(both && last_victim_q);
    init_done    = open;
    touch_acc    = touch_valid && touch_ready;
    victim_acc   = victim_valid && victim_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_cnt_q == SET_IDX_WIDTH'(NUM_OF_SETS - 1)) state_d = RUN;
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  // Stage 1: descend the tree for the victim, then flip every node on the
  // accessed way's leaf-to-root path to point at the sibling subtree.
  always_comb begin
    rd_tree = tree_mem[s1_set_q];
    walk    = (WAYS_IDX_WIDTH + 1)'(1);
    for (int unsigned lvl = 0; lvl < WAYS_IDX_WIDTH; lvl++) begin
      walk = {walk[WAYS_IDX_WIDTH-1:0], rd_tree[walk[WAYS_IDX_WIDTH-1:0]]};
    end
    vic_way  = walk[WAYS_IDX_WIDTH-1:0];
    upd_way  = s1_victim_q ? vic_way : s1_way_q;
    new_tree = rd_tree;
    climb    = {1'b1, upd_way};
    for (int unsigned lvl = 0; lvl < WAYS_IDX_WIDTH; lvl++) begin
      new_tree[climb[WAYS_IDX_WIDTH:1]] = ~climb[0];
      climb = climb >> 1;
    end
    new_tree[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= INIT;
      init_cnt_q       <= '0;
      last_victim_q    <= 1'b0;
      s1_valid_q       <= 1'b0;
      s1_victim_q      <= 1'b0;
      s1_set_q         <= '0;
      s1_way_q         <= '0;
      victim_rsp_valid <= 1'b0;
      victim_rsp_set   <= '0;
      victim_rsp_way   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= (state_q == INIT) ? init_cnt_q + 1'b1 : '0;
      if (touch_acc || victim_acc) last_victim_q <= victim_acc;
      s1_valid_q  <= touch_acc || victim_acc;
      s1_victim_q <= victim_acc;
      s1_set_q    <= victim_acc ? victim_set : touch_set;
      s1_way_q    <= touch_way;
      victim_rsp_valid <= s1_valid_q && s1_victim_q;
      if (s1_valid_q && s1_victim_q) begin
        victim_rsp_set <= s1_set_q;
        victim_rsp_way <= vic_way;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_OF_SETS; i++) tree_mem[i] <= '0;
    end else if (state_q == INIT) begin
      tree_mem[init_cnt_q] <= '0;
    end else if (s1_valid_q) begin
      tree_mem[s1_set_q] <= new_tree;
    end
  end

endmodule

// File: tb/tb_plru_replace_ctrl.sv
// Self-checking bench for plru_replace_ctrl: directed scenarios plus random
// traffic against a per-set tree model driven from the node/leaf rules.
module tb_plru_replace_ctrl;
  localparam int SETS = 64;
  localparam int WAYS = 4;
  localparam int SW   = 6;
  localparam int WW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          touch_valid = 1'b0, touch_ready;
  logic [SW-1:0] touch_set = '0;
  logic [WW-1:0] touch_way = '0;
  logic          victim_valid = 1'b0, victim_ready;
  logic [SW-1:0] victim_set = '0;
  logic          victim_rsp_valid;
  logic [SW-1:0] victim_rsp_set;
  logic [WW-1:0] victim_rsp_way;
  logic          flush_req = 1'b0;
  logic          init_done;

  plru_replace_ctrl #(.NUM_OF_SETS(SETS), .NUM_OF_WAYS(WAYS)) dut (
    .clk(clk), .rst_n(rst_n),
    .touch_valid(touch_valid), .touch_ready(touch_ready),
    .touch_set(touch_set), .touch_way(touch_way),
    .victim_valid(victim_valid), .victim_ready(victim_ready),
    .victim_set(victim_set),
    .victim_rsp_valid(victim_rsp_valid), .victim_rsp_set(victim_rsp_set),
    .victim_rsp_way(victim_rsp_way),
    .flush_req(flush_req), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: node values per set, node k children 2k (right) / 2k+1 (left).
  int  mtree [SETS][WAYS];
  int  init_left;
  bit  last_v;
  bit  e0v, e1v;
  int  e0s, e0w, e1s, e1w;
  bit  obs_ta, obs_va, obs_vr, obs_init;
  int  last_rsp_way;
  int  rsp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_victim(input int s);
    int n = 1;
    while (n < WAYS) n = 2 * n + mtree[s][n];
    return n - WAYS;
  endfunction

  task automatic model_touch(input int s, input int w);
    int n = w + WAYS;
    while (n > 1) begin
      mtree[s][n / 2] = (n % 2 == 0) ? 1 : 0;
      n = n / 2;
    end
  endtask

  task automatic clear_trees();
    for (int s = 0; s < SETS; s++)
      for (int k = 0; k < WAYS; k++) mtree[s][k] = 0;
  endtask

  task automatic model_reset();
    clear_trees();
    init_left = SETS;
    last_v = 1'b0;
    e0v = 1'b0; e1v = 1'b0;
    e0s = 0; e0w = 0; e1s = 0; e1w = 0;
  endtask

  // One clock cycle: drive at negedge, check at +1, advance model, wait next negedge.
  task automatic step(input bit tv, input int ts, input int tw,
                      input bit vv, input int vs, input bit fl);
    bit run, etr, evr, ta, va, n_v;
    int n_s, n_w;
    touch_valid = tv; touch_set = SW'(ts); touch_way = WW'(tw);
    victim_valid = vv; victim_set = SW'(vs); flush_req = fl;
    #1;
    run = (init_left == 0);
    etr = run && !fl && !(tv && vv && !last_v);
    evr = run && !fl && !(tv && vv && last_v);
    obs_ta   = tv && (touch_ready === 1'b1);
    obs_va   = vv && (victim_ready === 1'b1);
    obs_vr   = (victim_ready === 1'b1);
    obs_init = (init_done === 1'b1);
    chk("touch_ready",  32'(touch_ready),  32'(etr));
    chk("victim_ready", 32'(victim_ready), 32'(evr));
    chk("init_done",    32'(init_done),    32'(run && !fl));
    chk("rsp_valid",    32'(victim_rsp_valid), 32'(e1v));
    if (e1v) begin
      chk("rsp_set", 32'(victim_rsp_set), 32'(e1s));
      chk("rsp_way", 32'(victim_rsp_way), 32'(e1w));
    end
    if (victim_rsp_valid === 1'b1) begin
      last_rsp_way = int'(victim_rsp_way);
      rsp_q.push_back(last_rsp_way);
    end
    ta = tv && etr;
    va = vv && evr;
    n_v = 1'b0; n_s = 0; n_w = 0;
    if (va) begin
      n_w = model_victim(vs);
      model_touch(vs, n_w);
      n_v = 1'b1; n_s = vs;
    end
    if (ta) model_touch(ts, tw);
    e1v = e0v; e1s = e0s; e1w = e0w;
    e0v = n_v; e0s = n_s; e0w = n_w;
    if (ta || va) last_v = va;
    if (run && fl) begin
      init_left = SETS + 1;
      clear_trees();
    end else if (init_left > 0) begin
      init_left--;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"},    32'(victim_rsp_valid), 32'd0);
    chk({tag, "_rsp_set"},      32'(victim_rsp_set),   32'd0);
    chk({tag, "_rsp_way"},      32'(victim_rsp_way),   32'd0);
    chk({tag, "_touch_ready"},  32'(touch_ready),      32'd0);
    chk({tag, "_victim_ready"}, 32'(victim_ready),     32'd0);
    chk({tag, "_init_done"},    32'(init_done),        32'd0);
  endtask

  task automatic do_reset(input string tag);
    touch_valid = 1'b0; victim_valid = 1'b0; flush_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    chk({tag, "_held_rsp_valid"}, 32'(victim_rsp_valid), 32'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (n < SETS + 10) begin
      step(0, 0, 0, 0, 0, 0);
      if (obs_init) break;
      n++;
    end
    chk(tag, 32'(n), 32'(SETS));
  endtask

  initial begin
    int exp_seq [5];
    int acc, cnt;
    bit tv, vv, fl;
    exp_seq = '{0, 2, 1, 3, 0};
    rst_n = 1'b1;
    #2;
    do_reset("reset");
    wait_init("init_latency");

    // Simultaneous requests alternate, victim first after reset.
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 10, 1, 1, 11, 0);
      chk("tie_victim_grant", 32'(obs_va), 32'((i % 2) == 0));
      chk("tie_touch_grant",  32'(obs_ta), 32'((i % 2) == 1));
      acc += int'(obs_ta) + int'(obs_va);
    end
    chk("tie_accept_count", 32'(acc), 32'd4);
    idle(3);

    // Back-to-back victims on one set walk all ways.
    rsp_q.delete();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 3, 0);
    idle(2);
    chk("b2b_rsp_count", 32'(rsp_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < rsp_q.size()) chk("b2b_rsp_way", 32'(rsp_q[i]), 32'(exp_seq[i]));

    // Touch steers the victim; neighbouring set untouched.
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 0);
    idle(2);
    chk("touch_then_victim", 32'(last_rsp_way), 32'd2);
    step(0, 0, 0, 1, 6, 0);
    idle(2);
    chk("other_set_victim", 32'(last_rsp_way), 32'd0);

    // Flush with a victim in flight.
    step(0, 0, 0, 1, 7, 0);
    step(0, 0, 0, 1, 7, 0);
    idle(2);
    rsp_q.delete();
    step(0, 0, 0, 1, 7, 0);
    step(0, 0, 0, 0, 0, 1);
    cnt = 0;
    while (cnt < SETS + 10) begin
      step(0, 0, 0, 0, 0, 0);
      if (obs_vr) break;
      cnt++;
    end
    chk("flush_ready_low_cycles", 32'(cnt), 32'(SETS + 1));
    chk("flush_inflight_rsp", 32'(rsp_q.size()), 32'd1);
    step(0, 0, 0, 1, 7, 0);
    idle(2);
    chk("post_flush_victim", 32'(last_rsp_way), 32'd0);

    // Reset during S1 aborts the op.
    step(0, 0, 0, 1, 7, 0);
    rsp_q.delete();
    do_reset("midop_reset");
    wait_init("reinit_latency");
    chk("midop_no_rsp", 32'(rsp_q.size()), 32'd0);
    step(0, 0, 0, 1, 7, 0);
    idle(2);
    chk("post_reset_victim", 32'(last_rsp_way), 32'd0);

    // Random traffic concentrated on a few sets, occasional flush.
    for (int i = 0; i < 500; i++) begin
      tv = ($urandom_range(0, 99) < 55);
      vv = ($urandom_range(0, 99) < 55);
      fl = ($urandom_range(0, 99) < 2);
      step(tv, ($urandom_range(0, 9) == 0) ? $urandom_range(0, SETS - 1) : $urandom_range(0, 7),
           $urandom_range(0, WAYS - 1), vv, $urandom_range(0, 7), fl);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
